// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state, message codes and game defaults for the pong blocks
package pong_pkg;

  // Game sequencing states; the text and graph blocks decode the same values.
  typedef enum logic [1:0] {
    ST_NEWGAME = 2'd0,
    ST_PLAY    = 2'd1,
    ST_NEWBALL = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  // Text overlay selection codes.
  localparam logic [1:0] MSG_NONE  = 2'b00;
  localparam logic [1:0] MSG_START = 2'b01;
  localparam logic [1:0] MSG_OVER  = 2'b10;

  // Default game length and pause length (2 s at 60 frames/s).
  localparam int DEF_BALLS      = 3;
  localparam int DEF_WAIT_TICKS = 120;

endpackage

// File: rtl/pong_bcd2.sv
// rtl/pong_bcd2.sv - two-digit BCD up counter with clear and 99->00 wrap
module pong_bcd2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] d1,
  output logic [3:0] d0
);

  // Units digit rolls 9->0 and carries into tens; tens rolls 9->0 for the wrap.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      d1 <= 4'd0;
      d0 <= 4'd0;
    end else if (inc) begin
      if (d0 == 4'd9) begin
        d0 <= 4'd0;
        d1 <= (d1 == 4'd9) ? 4'd0 : d1 + 4'd1;
      end else begin
        d0 <= d0 + 4'd1;
      end
    end
  end

endmodule

// File: rtl/pong_ctrl.sv
// rtl/pong_ctrl.sv - pong game sequencing FSM: score, ball count and post-miss pause
module pong_ctrl
  import pong_pkg::*;
#(
  parameter int BALLS      = DEF_BALLS,
  parameter int WAIT_TICKS = DEF_WAIT_TICKS,
  parameter int TICK_W     = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       refr_tick,
  input  logic [1:0] btn,
  input  logic       hit,
  input  logic       miss,
  output logic       gra_still,
  output logic [1:0] msg_sel,
  output logic [3:0] score_d1,
  output logic [3:0] score_d0,
  output logic [1:0] balls_left
);

  localparam logic [1:0]        BALLS_FULL  = 2'(BALLS);
  localparam logic [1:0]        BALLS_SERVE = 2'(BALLS - 1);
  localparam logic [TICK_W-1:0] TIMER_LOAD  = TICK_W'(WAIT_TICKS);
  localparam logic [TICK_W-1:0] TIMER_ONE   = TICK_W'(1);

  state_t            state;
  state_t            state_next;
  logic [TICK_W-1:0] timer;
  logic              timer_zero;
  logic              in_pause;
  logic              ld_timer;
  logic              serve_balls;
  logic              dec_balls;
  logic              refill_balls;
  logic              score_inc;
  logic              score_clr;

  assign timer_zero = (timer == '0);
  assign in_pause   = (state == ST_NEWBALL) || (state == ST_OVER);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_NEWGAME;
    else     state <= state_next;
  end

  // Next-state and the one-cycle update strobes for score, balls and timer.
  always_comb begin
    state_next   = state;
    ld_timer     = 1'b0;
    serve_balls  = 1'b0;
    dec_balls    = 1'b0;
    refill_balls = 1'b0;
    score_inc    = 1'b0;
    score_clr    = 1'b0;
    case (state)
      ST_NEWGAME: begin
        if (btn != 2'b00) begin
          state_next  = ST_PLAY;
          serve_balls = 1'b1;
        end
      end
      ST_PLAY: begin
        // A miss wins over a simultaneous hit: the bounce never counted.
        if (miss) begin
          ld_timer = 1'b1;
          if (balls_left != 2'd0) begin
            dec_balls  = 1'b1;
            state_next = ST_NEWBALL;
          end else begin
            state_next = ST_OVER;
          end
        end else if (hit) begin
          score_inc = 1'b1;
        end
      end
      ST_NEWBALL: begin
        // Buttons must be released before the next serve.
        if (timer_zero && (btn == 2'b00)) state_next = ST_PLAY;
      end
      ST_OVER: begin
        if (timer_zero) begin
          state_next   = ST_NEWGAME;
          score_clr    = 1'b1;
          refill_balls = 1'b1;
        end
      end
      default: state_next = ST_NEWGAME;
    endcase
  end

  // Remaining reserve balls; the decrement strobe only fires when nonzero.
  always_ff @(posedge clk) begin
    if (rst || refill_balls) balls_left <= BALLS_FULL;
    else if (serve_balls)    balls_left <= BALLS_SERVE;
    else if (dec_balls)      balls_left <= balls_left - 2'd1;
  end

  // Frame-tick pause timer: loaded on entry to a pause, counts down to 0 and holds.
  always_ff @(posedge clk) begin
    if (rst)                                      timer <= '0;
    else if (ld_timer)                            timer <= TIMER_LOAD;
    else if (in_pause && refr_tick && !timer_zero) timer <= timer - TIMER_ONE;
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    gra_still = (state != ST_PLAY);
    case (state)
      ST_NEWGAME: msg_sel = MSG_START;
      ST_OVER:    msg_sel = MSG_OVER;
      default:    msg_sel = MSG_NONE;
    endcase
  end

  pong_bcd2 u_score (
    .clk (clk),
    .rst (rst),
    .clr (score_clr),
    .inc (score_inc),
    .d1  (score_d1),
    .d0  (score_d0)
  );

endmodule

// File: tb/tb_pong_ctrl.sv
// tb/tb_pong_ctrl.sv - directed scoreboard bench for pong_ctrl
module tb_pong_ctrl;

  localparam int S_NG = 0;
  localparam int S_PL = 1;
  localparam int S_NB = 2;
  localparam int S_OV = 3;

  typedef struct {
    string      tag;
    logic       gs;
    logic [1:0] ms;
    logic [3:0] d1;
    logic [3:0] d0;
    logic [1:0] bl;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       refr_tick;
  logic [1:0] btn;
  logic       hit;
  logic       miss;
  logic       gra_still;
  logic [1:0] msg_sel;
  logic [3:0] score_d1;
  logic [3:0] score_d0;
  logic [1:0] balls_left;

  int   checks;
  int   errors;
  int   m_score;
  int   m_balls;
  exp_t sb[$];

  pong_ctrl #(.BALLS(3), .WAIT_TICKS(120), .TICK_W(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .refr_tick  (refr_tick),
    .btn        (btn),
    .hit        (hit),
    .miss       (miss),
    .gra_still  (gra_still),
    .msg_sel    (msg_sel),
    .score_d1   (score_d1),
    .score_d0   (score_d0),
    .balls_left (balls_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Push the expected post-edge outputs, drive one cycle, then pop and compare.
  task automatic step(input string tag, input logic [1:0] b, input logic h, input logic m,
                      input logic t, input logic r, input int st);
    exp_t e;
    e.tag = tag;
    e.gs  = (st != S_PL);
    e.ms  = (st == S_NG) ? 2'b01 : (st == S_OV) ? 2'b10 : 2'b00;
    e.d1  = 4'(m_score / 10);
    e.d0  = 4'(m_score % 10);
    e.bl  = 2'(m_balls);
    sb.push_back(e);
    btn = b; hit = h; miss = m; refr_tick = t; rst = r;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".gra_still"},  8'(gra_still),  8'(e.gs));
    check({e.tag, ".msg_sel"},    8'(msg_sel),    8'(e.ms));
    check({e.tag, ".score_d1"},   8'(score_d1),   8'(e.d1));
    check({e.tag, ".score_d0"},   8'(score_d0),   8'(e.d0));
    check({e.tag, ".balls_left"}, 8'(balls_left), 8'(e.bl));
  endtask

  // 120 frame ticks separated by idle cycles; state must hold throughout.
  task automatic pause(input logic [1:0] b, input int st, input int n);
    for (int i = 1; i <= n; i++) begin
      step("tick", b, 1'b0, 1'b0, 1'b1, 1'b0, st);
      if (i < n) step("wait", b, 1'b0, 1'b0, 1'b0, 1'b0, st);
    end
  endtask

  task automatic hits(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      m_score = (m_score + 1) % 100;
      step(tag, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, S_PL);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    btn = 2'b00; hit = 1'b0; miss = 1'b0; refr_tick = 1'b0; rst = 1'b1;
    m_score = 0; m_balls = 3;

    step("rst0", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, S_NG);
    step("rst1", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, S_NG);
    for (int i = 0; i < 10; i++) step("idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, S_NG);
    step("ng_hit", 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, S_NG);

    m_balls = 2;
    step("start", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, S_PL);
    step("play", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, S_PL);

    hits("hit12", 12);
    hits("hit_to_00", 88);
    hits("hit_to_99", 99);
    hits("hit_wrap", 1);
    hits("hit3", 3);

    m_balls = 1;
    step("hit_miss", 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, S_NB);
    step("nb_hit", 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, S_NB);
    step("nb_miss", 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, S_NB);
    pause(2'b10, S_NB, 120);
    for (int i = 0; i < 3; i++) step("nb_hold", 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, S_NB);
    step("nb_release", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, S_PL);

    m_balls = 0;
    step("miss2", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, S_NB);
    pause(2'b00, S_NB, 120);
    step("serve3", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, S_PL);
    step("miss_last", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, S_OV);
    step("ov_hit", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, S_OV);
    step("ov_btn", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, S_OV);
    pause(2'b00, S_OV, 120);
    m_score = 0; m_balls = 3;
    step("ov_exit", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, S_NG);

    m_balls = 2;
    step("g2_start", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, S_PL);
    hits("g2_hit", 5);
    m_balls = 1;
    step("g2_miss1", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, S_NB);
    pause(2'b00, S_NB, 120);
    step("g2_serve2", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, S_PL);
    m_balls = 0;
    step("g2_miss2", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, S_NB);
    pause(2'b00, S_NB, 120);
    step("g2_serve3", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, S_PL);
    step("g2_miss3", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, S_OV);
    pause(2'b00, S_OV, 119);
    step("g2_ov119", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, S_OV);
    step("g2_tick120", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, S_OV);
    m_score = 0; m_balls = 3;
    step("g2_exit", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, S_NG);

    m_balls = 2;
    step("g3_start", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, S_PL);
    hits("g3_hit", 4);
    m_balls = 1;
    step("g3_miss", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, S_NB);
    pause(2'b00, S_NB, 60);
    m_score = 0; m_balls = 3;
    step("rst_mid", 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, S_NG);
    for (int i = 0; i < 3; i++) step("post_rst_hit", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, S_NG);
    step("post_rst_tick", 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, S_NG);
    m_balls = 2;
    step("g4_start", 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, S_PL);
    hits("g4_hit", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_ctrl.md
# pong_ctrl

Game-sequencing controller for the pong graphics datapath. It owns the game state machine (new game, play, new ball, game over). It freezes and releases the ball/paddle animation through `gra_still`, counts paddle hits into a two-digit BCD score, tracks remaining balls, and times the pause after each miss using frame ticks. It sits between the VGA sync/button logic and the graph-animation and text-overlay blocks.

## Interface
Parameters:
- `BALLS`, 3: balls per game, including the ball in play.
- `WAIT_TICKS`, 120: frames to pause after a miss or game over (2 s at 60 Hz).
- `TICK_W`, 7: timer width; must satisfy `WAIT_TICKS < 2**TICK_W`.

Ports:
- `clk`  in  1  system/pixel clock.
- `rst`  in  1  reset; synchronous, active-high.
- `refr_tick`  in  1  one-cycle pulse per frame (start of v-sync).
- `btn`  in  2  paddle buttons, level, already debounced; any bit high counts as "pressed".
- `hit`  in  1  one-cycle pulse: ball bounced off the paddle.
- `miss`  in  1  one-cycle pulse: ball passed the paddle.
- `gra_still`  out  1  1 = datapath holds ball and paddle at their initial positions.
- `msg_sel`  out  2  text overlay select: 00 none, 01 "press to start", 10 "game over".
- `score_d1`  out  4  score tens digit, BCD.
- `score_d0`  out  4  score units digit, BCD.
- `balls_left`  out  2  reserve balls not yet served.

## Operation
- FSM states: NEWGAME, PLAY, NEWBALL, OVER. All outputs are registered or decoded from the state register only (Moore).
- NEWGAME:
  - Outputs: `gra_still`=1, `msg_sel`=01.
  - When `btn`!=0: go to PLAY and load `balls_left` = BALLS-1.
- PLAY:
  - Outputs: `gra_still`=0, `msg_sel`=00.
  - `hit`: score increments by 1, BCD. Units 9 rolls to 0 with a carry into tens. 99 wraps to 00.
  - `miss` with `balls_left`!=0: decrement `balls_left`, load timer, go to NEWBALL.
  - `miss` with `balls_left`==0: load timer, go to OVER.
  - `hit` and `miss` in the same cycle: the miss is processed and the score is unchanged.
- NEWBALL:
  - Outputs: `gra_still`=1, `msg_sel`=00.
  - Go to PLAY when the timer is 0 and `btn`==0. The player must release the buttons before the next serve.
- OVER:
  - Outputs: `gra_still`=1, `msg_sel`=10.
  - When the timer reaches 0: go to NEWGAME, clear score to 00, set `balls_left` = BALLS.
- Timer:
  - Load: set to WAIT_TICKS on the same edge as entry to NEWBALL/OVER.
  - Count: decrements on `refr_tick` while nonzero; holds at 0.
  - Scope: ignored outside NEWBALL/OVER.
- `hit`/`miss` outside PLAY are ignored. `refr_tick` has no effect on state except through the timer.

## Timing
- Reset values: state NEWGAME, `gra_still`=1, `msg_sel`=01, score 00, `balls_left`=BALLS, timer 0.
- Reset mid-game aborts any state on the next edge. A reset cycle ignores all other inputs.
- Latency:
  - Score and `balls_left` update on the first edge after the pulse; visible the next cycle.
  - `gra_still` changes on the same edge as the state.
- Pause length: NEWBALL/OVER last exactly WAIT_TICKS `refr_tick` pulses (plus any button-hold time in NEWBALL) before the exit condition can be met.
- Button press in NEWGAME: PLAY is entered on the next edge. `btn` is level-sensitive, so no edge detect is required there.
- Widths:
  - BCD digits are 4 bits and never exceed 9.
  - `balls_left` never underflows; decrement only occurs when it is nonzero.

## Structure
- Shared package `pong_pkg`:
  - State encoding localparams (NEWGAME=0, PLAY=1, NEWBALL=2, OVER=3).
  - `msg_sel` codes.
  - Default BALLS and WAIT_TICKS; the text and graph blocks use the same codes.
- Sub-module `pong_bcd2`:
  - Ports: clk, rst, clr, inc, d1, d0.
  - Two-digit BCD counter with wrap.
  - Instantiated once for the score.
- The frame-tick timer stays inline.

## Test plan
- Reset, then idle 10 cycles: state NEWGAME, `gra_still`=1, `msg_sel`=01, score 00, `balls_left`=3.
- Press `btn`=01 one cycle: next cycle `gra_still`=0, `balls_left`=2. Then 12 `hit` pulses: score 1/2. Then 99 hits from 00: score 9/9; one more hit gives 0/0.
- In PLAY, `miss` with `btn` held: NEWBALL, `balls_left` decrements. After 120 `refr_tick`s it stays in NEWBALL until `btn`=00, then PLAY one cycle later.
- `hit` and `miss` asserted in the same cycle in PLAY: score unchanged and NEWBALL entered.
- Three misses from a fresh game: OVER with `msg_sel`=10. After 119 ticks it is still OVER. After tick 120, NEWGAME with score 00 and `balls_left`=3.
- `rst` asserted one cycle mid-NEWBALL with the timer at 60: all reset values restored; subsequent `hit` pulses are ignored until `btn` starts a game.
